// File: rtl/nf10_reg_pkg.sv
// rtl/nf10_reg_pkg.sv - shared FSM state encoding and AXI response codes for nf10_reg_master
package nf10_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // EXOKAY is also counted: anything other than a plain OKAY is flagged.
  function automatic logic resp_nonzero(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/nf10_reg_master.sv
// rtl/nf10_reg_master.sv - AXI4-Lite single-outstanding register master
// Define NF10_REG_MASTER_STATS_EN to add the stat_wr_cnt/stat_rd_cnt/stat_err_cnt counters.
module nf10_reg_master
  import nf10_reg_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_be,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
`ifdef NF10_REG_MASTER_STATS_EN
  ,
  output logic [31:0]                     stat_wr_cnt,
  output logic [31:0]                     stat_rd_cnt,
  output logic [31:0]                     stat_err_cnt
`endif
);

  state_t                          r_state;
  state_t                          w_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_data;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] r_be;
  logic                            r_aw_done;
  logic                            r_w_done;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rsp_data;
  logic [1:0]                      r_rsp_resp;

  logic w_cmd_ready;
  logic w_awvalid;
  logic w_wvalid;
  logic w_bready;
  logic w_arvalid;
  logic w_rready;
  logic w_rsp_valid;
  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_r_hs;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Handshake terms are written out inline so the block never reads its own outputs.
  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_bready    = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmd_ready = !M_AXI_ARESET;
        if (cmd_valid && !M_AXI_ARESET) begin
          w_next = cmd_rnw ? ST_RD_REQ : ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) begin
          w_next = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        w_bready = 1'b1;
        if (M_AXI_BVALID) begin
          w_next = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        w_arvalid = 1'b1;
        if (M_AXI_ARREADY) begin
          w_next = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        w_rready = 1'b1;
        if (M_AXI_RVALID) begin
          w_next = ST_RSP;
        end
      end
      ST_RSP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_cmd_hs = cmd_valid && w_cmd_ready;
  assign w_aw_hs  = w_awvalid && M_AXI_AWREADY;
  assign w_w_hs   = w_wvalid && M_AXI_WREADY;
  assign w_b_hs   = w_bready && M_AXI_BVALID;
  assign w_r_hs   = w_rready && M_AXI_RVALID;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_be       <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_resp <= RESP_OKAY;
    end else begin
      if (w_cmd_hs) begin
        r_addr <= cmd_addr;
        r_data <= cmd_data;
        r_be   <= cmd_be;
      end
      // AW and W complete independently; each VALID falls the cycle after its own handshake.
      if (r_state == ST_WR_REQ) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_b_hs) begin
        r_rsp_data <= '0;
        r_rsp_resp <= M_AXI_BRESP;
      end
      if (w_r_hs) begin
        r_rsp_data <= M_AXI_RDATA;
        r_rsp_resp <= M_AXI_RRESP;
      end
    end
  end

`ifdef NF10_REG_MASTER_STATS_EN
  logic [31:0] r_stat_wr;
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_err;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_stat_wr  <= '0;
      r_stat_rd  <= '0;
      r_stat_err <= '0;
    end else begin
      if (w_b_hs) r_stat_wr <= r_stat_wr + 32'd1;
      if (w_r_hs) r_stat_rd <= r_stat_rd + 32'd1;
      if ((w_b_hs && resp_nonzero(M_AXI_BRESP)) || (w_r_hs && resp_nonzero(M_AXI_RRESP))) begin
        r_stat_err <= r_stat_err + 32'd1;
      end
    end
  end

  assign stat_wr_cnt  = r_stat_wr;
  assign stat_rd_cnt  = r_stat_rd;
  assign stat_err_cnt = r_stat_err;
`endif

  assign cmd_ready     = w_cmd_ready;
  assign rsp_valid     = w_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_resp      = r_rsp_resp;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_WDATA   = r_data;
  assign M_AXI_WSTRB   = r_be;
  assign M_AXI_WVALID  = w_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = w_arvalid;
  assign M_AXI_RREADY  = w_rready;

endmodule
